morse_decoder: RTL and testbench

//  Receive-side counterpart of the Lab 5 Morse encoder. Samples a serial Morse line once per

---
 rtl/morse_decoder_if.sv | 12 +
 rtl/morse_decoder.sv | 168 ++++++++++++++++
 tb/tb_morse_decoder.sv | 178 +++++++++++++++++
 3 files changed

// File: rtl/morse_decoder_if.sv
// Sample strobe, Morse line and decoded-letter outputs of the Morse receiver.
interface morse_decoder_if;
  logic       tick;
  logic       din;
  logic [2:0] letter;
  logic       valid;
  logic       err;
  logic       busy;

  modport master (output tick, din, input letter, valid, err, busy);
  modport slave  (input tick, din, output letter, valid, err, busy);
endinterface

// File: rtl/morse_decoder.sv
// Morse receiver: times marks/spaces per sample tick, classifies dot/dash and
// maps the finished pattern onto the 3-bit letter code A..H.
module morse_decoder #(
  parameter int unsigned MAX_SYMBOLS = 4,
  parameter int unsigned DASH_MIN    = 2,
  parameter int unsigned DASH_MAX    = 3,
  parameter int unsigned END_GAP     = 3
) (
  input  logic            clk,
  input  logic            reset,
  morse_decoder_if.slave  bus
);

  localparam int unsigned SYM_W  = (MAX_SYMBOLS > 4) ? MAX_SYMBOLS : 4;
  localparam int unsigned CNT_W  = $clog2(MAX_SYMBOLS + 2);
  localparam int unsigned MARK_W = $clog2(DASH_MAX + 2);
  localparam int unsigned GAP_W  = $clog2(END_GAP + 1);

  typedef enum logic [2:0] {IDLE, MARK, SPACE, RESOLVE, DRAIN} state_t;

  state_t            state, state_n;
  logic [MARK_W-1:0] mark_cnt, mark_n, mark_inc;
  logic [GAP_W-1:0]  gap_cnt, gap_n, gap_inc;
  logic [CNT_W-1:0]  sym_cnt, symcnt_n;
  logic [SYM_W-1:0]  sym, sym_n;
  logic [2:0]        letter_q, letter_n, code;
  logic              valid_q, valid_n, err_q, err_n, busy_q, match;
  logic [7:0]        key;

  assign bus.letter = letter_q;
  assign bus.valid  = valid_q;
  assign bus.err    = err_q;
  assign bus.busy   = busy_q;

  // Symbols shift in MSB-first, 1 = dash; key is {count, last four symbols}.
  always_comb begin
    key   = {4'(sym_cnt), sym[3:0]};
    match = 1'b1;
    code  = '0;
    case (key)
      8'h21:   code = 3'd0;
      8'h48:   code = 3'd1;
      8'h4A:   code = 3'd2;
      8'h34:   code = 3'd3;
      8'h10:   code = 3'd4;
      8'h42:   code = 3'd5;
      8'h36:   code = 3'd6;
      8'h40:   code = 3'd7;
      default: match = 1'b0;
    endcase
  end

  always_comb begin
    state_n  = state;
    mark_n   = mark_cnt;
    gap_n    = gap_cnt;
    symcnt_n = sym_cnt;
    sym_n    = sym;
    letter_n = letter_q;
    valid_n  = 1'b0;
    err_n    = 1'b0;
    mark_inc = (mark_cnt == '1) ? mark_cnt : mark_cnt + 1'b1;
    gap_inc  = (gap_cnt == '1) ? gap_cnt : gap_cnt + 1'b1;
    case (state)
      IDLE: begin
        if (bus.tick && bus.din) begin
          state_n  = MARK;
          mark_n   = MARK_W'(1);
          symcnt_n = '0;
          sym_n    = '0;
          gap_n    = '0;
        end
      end
      MARK: begin
        if (bus.tick) begin
          if (bus.din) begin
            mark_n = mark_inc;
            if (mark_inc > MARK_W'(DASH_MAX)) begin
              state_n = DRAIN;
              gap_n   = '0;
            end
          end else if (sym_cnt == CNT_W'(MAX_SYMBOLS)) begin
            // The terminating low already counts toward the drain gap.
            gap_n = GAP_W'(1);
            if (END_GAP <= 1) begin
              err_n   = 1'b1;
              state_n = IDLE;
            end else begin
              state_n = DRAIN;
            end
          end else begin
            sym_n    = {sym[SYM_W-2:0], (mark_cnt >= MARK_W'(DASH_MIN))};
            symcnt_n = sym_cnt + 1'b1;
            gap_n    = GAP_W'(1);
            state_n  = (END_GAP <= 1) ? RESOLVE : SPACE;
          end
        end
      end
      SPACE: begin
        if (bus.tick) begin
          if (bus.din) begin
            state_n = MARK;
            mark_n  = MARK_W'(1);
          end else begin
            gap_n = gap_inc;
            if (gap_inc >= GAP_W'(END_GAP)) state_n = RESOLVE;
          end
        end
      end
      RESOLVE: begin
        if (match) begin
          letter_n = code;
          valid_n  = 1'b1;
        end else begin
          err_n = 1'b1;
        end
        state_n = IDLE;
        // A tick landing on this cycle is handled as the first IDLE sample.
        if (bus.tick && bus.din) begin
          state_n  = MARK;
          mark_n   = MARK_W'(1);
          symcnt_n = '0;
          sym_n    = '0;
          gap_n    = '0;
        end
      end
      DRAIN: begin
        if (bus.tick) begin
          if (bus.din) begin
            gap_n = '0;
          end else begin
            gap_n = gap_inc;
            if (gap_inc >= GAP_W'(END_GAP)) begin
              err_n   = 1'b1;
              state_n = IDLE;
            end
          end
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state    <= IDLE;
      mark_cnt <= '0;
      gap_cnt  <= '0;
      sym_cnt  <= '0;
      sym      <= '0;
      letter_q <= '0;
      valid_q  <= 1'b0;
      err_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state    <= state_n;
      mark_cnt <= mark_n;
      gap_cnt  <= gap_n;
      sym_cnt  <= symcnt_n;
      sym      <= sym_n;
      letter_q <= letter_n;
      valid_q  <= valid_n;
      err_q    <= err_n;
      busy_q   <= (state_n != IDLE);
    end
  end

endmodule

// File: tb/tb_morse_decoder.sv
// Bench for morse_decoder: letter vectors against a pulse scoreboard plus
// hand-built latency, tick-gating, reset and back-to-back sequences.
module tb_morse_decoder;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  morse_decoder_if bus();

  morse_decoder #(
    .MAX_SYMBOLS(4),
    .DASH_MIN(2),
    .DASH_MAX(3),
    .END_GAP(3)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  typedef struct packed {
    logic       is_err;
    logic [2:0] letter;
  } exp_t;

  typedef struct {
    logic [31:0] bits;
    int          len;
    logic        is_err;
    logic [2:0]  letter;
  } vec_t;

  exp_t       exp_q[$];
  vec_t       vecs[13];
  int         tests = 0;
  int         fails = 0;
  logic [2:0] last_good = 3'd0;

  task automatic check(input string name, input int got, input int want);
    tests++;
    if (got != want) begin
      fails++;
      $display("FAIL %s: got %0d expected %0d at %0t", name, got, want, $time);
    end
  endtask

  task automatic expect_pulse(input logic is_err, input logic [2:0] letter);
    exp_t e;
    e.is_err = is_err;
    e.letter = is_err ? last_good : letter;
    if (!is_err) last_good = letter;
    exp_q.push_back(e);
  endtask

  // Called at a negedge; tick is high across exactly one posedge.
  task automatic drive(input logic b, input int gap);
    bus.din  = b;
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    repeat (gap) @(negedge clk);
  endtask

  task automatic drive_bits(input logic [31:0] bits, input int len, input int gap);
    for (int i = len - 1; i >= 0; i--) drive(bits[i], gap);
  endtask

  always @(negedge clk) begin
    exp_t e;
    if (bus.valid || bus.err) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL unexpected_pulse: valid=%0b err=%0b letter=%0d at %0t",
                 bus.valid, bus.err, bus.letter, $time);
      end else begin
        e = exp_q.pop_front();
        check("pulse_kind", int'({bus.valid, bus.err}), e.is_err ? 1 : 2);
        check("pulse_letter", int'(bus.letter), int'(e.letter));
      end
    end
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{32'b10111000,       8,  1'b0, 3'd0};
    vecs[1]  = '{32'b1010101000,     10, 1'b0, 3'd7};
    vecs[2]  = '{32'b11101011101000, 14, 1'b0, 3'd2};
    vecs[3]  = '{32'b1000,           4,  1'b0, 3'd4};
    vecs[4]  = '{32'b101010101000,   12, 1'b1, 3'd0};
    vecs[5]  = '{32'b1111000,        7,  1'b1, 3'd0};
    vecs[6]  = '{32'b111101000,      9,  1'b1, 3'd0};
    vecs[7]  = '{32'b11011000,       8,  1'b1, 3'd0};
    vecs[8]  = '{32'b11010101000,    11, 1'b0, 3'd1};
    vecs[9]  = '{32'b1101101000,     10, 1'b0, 3'd6};
    vecs[10] = '{32'b110101000,      9,  1'b0, 3'd3};
    vecs[11] = '{32'b10101101000,    11, 1'b0, 3'd5};
    vecs[12] = '{32'b10011000,       8,  1'b0, 3'd0};

    reset    = 1'b1;
    bus.tick = 1'b0;
    bus.din  = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_letter", int'(bus.letter), 0);
    check("rst_valid", int'(bus.valid), 0);
    check("rst_err", int'(bus.err), 0);
    check("rst_busy", int'(bus.busy), 0);
    reset = 1'b0;
    @(negedge clk);

    // A with exact output latency after the final low tick
    expect_pulse(1'b0, 3'd0);
    drive_bits(32'b1011100, 7, 3);
    bus.din  = 1'b0;
    bus.tick = 1'b1;
    @(negedge clk);
    bus.tick = 1'b0;
    check("lat_resolve_valid", int'(bus.valid), 0);
    check("lat_resolve_busy", int'(bus.busy), 1);
    @(negedge clk);
    check("lat_out_valid", int'(bus.valid), 1);
    check("lat_out_letter", int'(bus.letter), 0);
    check("lat_out_busy", int'(bus.busy), 0);
    @(negedge clk);
    check("lat_after_valid", int'(bus.valid), 0);
    repeat (2) @(negedge clk);

    foreach (vecs[k]) begin
      expect_pulse(vecs[k].is_err, vecs[k].letter);
      drive_bits(vecs[k].bits, vecs[k].len, 3);
      check("vec_busy_idle", int'(bus.busy), 0);
    end

    // din wiggles with tick low must not disturb a letter in progress
    expect_pulse(1'b0, 3'd0);
    drive_bits(32'b101110, 6, 3);
    for (int i = 0; i < 8; i++) begin
      bus.din = ~bus.din;
      @(negedge clk);
    end
    check("gated_busy", int'(bus.busy), 1);
    drive_bits(32'b00, 2, 3);

    // second E starts on the tick that coincides with RESOLVE
    expect_pulse(1'b0, 3'd4);
    expect_pulse(1'b0, 3'd4);
    drive_bits(32'b10001000, 8, 0);
    repeat (4) @(negedge clk);
    check("b2b_busy", int'(bus.busy), 0);

    // reset in the middle of B discards it, then E decodes
    drive_bits(32'b1101, 4, 3);
    check("midb_busy", int'(bus.busy), 1);
    reset = 1'b1;
    @(negedge clk);
    check("midb_rst_letter", int'(bus.letter), 0);
    check("midb_rst_busy", int'(bus.busy), 0);
    reset = 1'b0;
    last_good = 3'd0;
    @(negedge clk);
    expect_pulse(1'b0, 3'd4);
    drive_bits(32'b1000, 4, 3);
    check("e_after_rst_letter", int'(bus.letter), 4);

    for (int i = 0; i < 50 && exp_q.size() != 0; i++) @(negedge clk);
    check("scoreboard_empty", exp_q.size(), 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
